// File: rtl/combo_pkg.sv
// Shared types and default parameters for the combination-lock sequence checker.
package combo_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } combo_state_t;

  localparam int          DEF_CODE_LEN    = 4;
  localparam int          DEF_DIGIT_W     = 4;
  localparam logic [15:0] DEF_CODE        = 16'h1234;
  localparam int          DEF_MAX_FAILS   = 3;
  localparam int          DEF_LOCK_CYCLES = 16;

endpackage

// File: rtl/combo_check_edge_detect.sv
// Rising-edge detector; the history register resets to RST_VAL so a level
// already high when reset is released does not count as an edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= RST_VAL;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/combo_check.sv
// Combination sequence checker: samples digit on each enter rise and compares
// the whole sequence with CODE. Optional lockout via `COMBO_LOCKOUT_EN.
module combo_check
  import combo_pkg::*;
#(
  parameter int                            CODE_LEN    = DEF_CODE_LEN,
  parameter int                            DIGIT_W     = DEF_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE        = DEF_CODE,
  parameter int                            MAX_FAILS   = DEF_MAX_FAILS,
  parameter int                            LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             enter,
  input  logic                             relock,
  output logic                             unlocked,
  output logic                             error,
  output logic                             locked_out,
  output logic [$clog2(CODE_LEN)-1:0]      pos,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int POS_W  = $clog2(CODE_LEN);
  localparam int FAIL_W = $clog2(MAX_FAILS+1);

  logic               rise;
  logic               rise_q;
  logic               relock_q;
  logic [DIGIT_W-1:0] digit_q;

  combo_state_t       state, state_n;
  logic [POS_W-1:0]   pos_n;
  logic [FAIL_W-1:0]  fail_n, fail_inc;
  logic               mism, mism_n, miss;
  logic               error_n;
  logic [DIGIT_W-1:0] cur_digit;

  edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (enter),
    .rise (rise)
  );

  // Edge, digit and relock are registered together so the FSM acts one cycle
  // after the sampling edge and relock/edge collisions are seen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q   <= 1'b0;
      relock_q <= 1'b0;
      digit_q  <= '0;
    end else begin
      rise_q   <= rise;
      relock_q <= relock;
      digit_q  <= digit;
    end
  end

`ifdef COMBO_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCK_CYCLES+1);
  logic [LOCK_W-1:0] lock_cnt, lock_n;

  always_ff @(posedge clk) begin
    if (rst) lock_cnt <= '0;
    else     lock_cnt <= lock_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ENTRY;
      pos      <= '0;
      fail_cnt <= '0;
      mism     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      fail_cnt <= fail_n;
      mism     <= mism_n;
      error    <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    fail_n    = fail_cnt;
    mism_n    = mism;
    error_n   = 1'b0;
`ifdef COMBO_LOCKOUT_EN
    lock_n    = lock_cnt;
`endif
    cur_digit = CODE[(CODE_LEN - int'(pos))*DIGIT_W - 1 -: DIGIT_W];
    miss      = mism | (digit_q != cur_digit);
    fail_inc  = (fail_cnt == FAIL_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;

    unique case (state)
      ENTRY: begin
        if (rise_q) begin
          if (pos == POS_W'(CODE_LEN-1)) begin
            pos_n  = '0;
            mism_n = 1'b0;
            if (!miss) begin
              state_n = OPEN;
              fail_n  = '0;
            end else begin
              error_n = 1'b1;
              fail_n  = fail_inc;
`ifdef COMBO_LOCKOUT_EN
              if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                state_n = LOCKOUT;
                lock_n  = LOCK_W'(LOCK_CYCLES);
              end
`endif
            end
          end else begin
            pos_n  = pos + 1'b1;
            mism_n = miss;
          end
        end
      end
      OPEN: begin
        if (relock_q) begin
          state_n = ENTRY;
          pos_n   = '0;
        end
      end
      LOCKOUT: begin
`ifdef COMBO_LOCKOUT_EN
        // Exiting on the count-1 edge keeps locked_out high for LOCK_CYCLES cycles.
        if (lock_cnt == LOCK_W'(1)) begin
          state_n = ENTRY;
          fail_n  = '0;
          pos_n   = '0;
          lock_n  = '0;
        end else begin
          lock_n  = lock_cnt - 1'b1;
        end
`else
        state_n = ENTRY;
`endif
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked = (state == OPEN);
`ifdef COMBO_LOCKOUT_EN
  assign locked_out = (state == LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: doc/combo_check.md
# combo_check

Sequence checker downstream of the up/down digit counter in the FPGA combination lock. It samples the counter's 4-bit digit on each rising edge of the debounced `enter` button and compares the full entered sequence against a parameterised code. It drives the `unlocked` indication and reports failed attempts. Repeated failures can optionally trigger a timed lockout.

## Interface
- `CODE_LEN`, 4: digits per combination.
- `DIGIT_W`, 4: digit width; matches the counter's `numOut`.
- `CODE`, 16'h1234: packed code, CODE_LEN*DIGIT_W bits; the MSB digit is entered first.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout; must be ≥1.
- `LOCK_CYCLES`, 16: lockout duration in clk cycles; must be ≥1.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `digit` in DIGIT_W: current counter value (`numOut`).
- `enter` in 1: debounced enter level; internally edge-detected.
- `relock` in 1: level; returns OPEN to ENTRY.
- `unlocked` out 1: high while in OPEN.
- `error` out 1: one-cycle pulse on a failed attempt.
- `locked_out` out 1: high while in LOCKOUT.
- `pos` out $clog2(CODE_LEN): index of the next digit to be entered.
- `fail_cnt` out $clog2(MAX_FAILS+1): consecutive failures since the last success or lockout.

## Operation
- States: ENTRY, OPEN, LOCKOUT. Reset enters ENTRY.
- Reset values:
  - `unlocked`=0, `error`=0, `locked_out`=0, `pos`=0, `fail_cnt`=0.
  - Mismatch flag cleared.
  - Edge register `enter_q`=1, so an `enter` held through reset produces no edge.
- Edge definition: `edge = enter & ~enter_q`. `enter_q` updates every cycle.

ENTRY
- On `edge`, `digit` is compared with code digit `pos`. Digit k = CODE[(CODE_LEN-k)*DIGIT_W-1 -: DIGIT_W].
- A mismatch sets a sticky flag. The block does not indicate which digit was wrong and does not abort early.
- If `pos` < CODE_LEN-1: `pos` increments.
- If `pos` = CODE_LEN-1, the attempt completes and `pos` returns to 0:
  - No mismatch (including the final digit): go to OPEN; `fail_cnt` cleared.
  - Otherwise: `error` pulses and `fail_cnt` increments.
    - If the new count equals MAX_FAILS and lockout is compiled in: go to LOCKOUT.
    - Otherwise: stay in ENTRY.
  - Mismatch flag cleared in either case.

OPEN
- `enter` edges are ignored.
- `relock`=1: go to ENTRY; `pos`=0.
- If `relock` and an edge occur in the same cycle, relock wins and the edge is discarded.

LOCKOUT
- `enter` edges are ignored.
- A down-counter loads LOCK_CYCLES on entry and decrements each cycle.
- When it reaches 0: go to ENTRY with `fail_cnt`=0 and `pos`=0.

General
- `fail_cnt` saturates at MAX_FAILS; it never wraps.
- `rst` asserted in any state restores reset values on the next edge. A partial sequence is discarded.

## Timing
- All outputs are registered.
- An `enter` rising level sampled at clock edge N produces its effect (`pos`, `unlocked`, `error`) visible after edge N+1.
- `digit` is sampled at the same edge as the `enter` rise.
- `error` is high for exactly one cycle per failed attempt.
- `relock` sampled at edge N: `unlocked`=0 after edge N+1.
- `locked_out` is high for exactly LOCK_CYCLES cycles, then deasserts; ENTRY accepts edges from the following cycle.
- Consecutive edges need `enter` low for ≥1 cycle between them. Maximum accept rate is one digit per 2 cycles.

## Configuration
- `COMBO_LOCKOUT_EN` defined: LOCKOUT state, lockout counter and saturation at MAX_FAILS behave as above.
- `COMBO_LOCKOUT_EN` undefined:
  - No LOCKOUT state and no counter; `locked_out` is tied to 0.
  - Failed attempts always return to ENTRY.
  - `fail_cnt` still counts and saturates at MAX_FAILS.

## Structure
- Package `combo_pkg`:
  - State enum `combo_state_t` (ENTRY, OPEN, LOCKOUT).
  - Default-code and default-timing localparams shared with the top level and bench.
- Sub-module `edge_detect`: rising-edge detector with a parameterised reset value for its register, instantiated with reset value 1. Everything else lives in `combo_check`.

## Test plan
1. **Correct code.** Defaults; edges with digits 1,2,3,4.
   - `pos` steps 1,2,3,0.
   - `unlocked`=1 the cycle after the 4th edge.
   - `error` never asserts.
2. **Wrong digit.** Digits 1,2,9,4.
   - No reaction until the 4th edge.
   - Then `error` pulses 1 cycle; `fail_cnt`=1; `unlocked`=0; `pos`=0.
3. **Lockout.** `COMBO_LOCKOUT_EN` defined; three wrong attempts.
   - `locked_out`=1 for 16 cycles; edges during that time are ignored.
   - Afterwards `fail_cnt`=0, and a correct code unlocks.
4. **Relock priority.** In OPEN, assert `relock` together with an `enter` rise.
   - `unlocked`=0 next cycle; `pos`=0, because the edge is discarded.
5. **Reset mid-entry.**
   - `enter` held high through reset: no digit is accepted.
   - After 2 correct digits, pulse `rst`: `pos`=0. Then 3,4,1,2 fails and 1,2,3,4 unlocks.
6. **No-lockout build.** `COMBO_LOCKOUT_EN` undefined; five wrong attempts.
   - `locked_out` stays 0; `fail_cnt` saturates at 3.
   - A subsequent correct code unlocks and clears `fail_cnt`.
